// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, operation codes, FSM state encoding and
// the single-cycle evaluation used by both the ALU control stage and alu_seq.
package alu_pkg;

    localparam int DATA_W  = 64;
    localparam int SHAMT_W = 6;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_ORR   = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_LSL   = 4'b0011,
        OP_SUB   = 4'b0110,
        OP_PASSB = 4'b0111,
        OP_PASSA = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } alu_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              c;
        logic              v;
        logic              illegal;
    } alu_res_t;

    // Subtraction is a + ~b + 1, so the carry out is already "not borrow".
    function automatic alu_res_t alu_eval(input logic [3:0]         op,
                                          input logic [DATA_W-1:0]  a,
                                          input logic [DATA_W-1:0]  b,
                                          input logic [SHAMT_W-1:0] shamt);
        alu_res_t          r;
        logic [DATA_W:0]   wide;
        r    = '0;
        wide = '0;
        case (op)
            OP_AND:   r.res = a & b;
            OP_ORR:   r.res = a | b;
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                r.res = wide[DATA_W-1:0];
                r.c   = wide[DATA_W];
                r.v   = (a[DATA_W-1] == b[DATA_W-1]) && (r.res[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                wide  = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
                r.res = wide[DATA_W-1:0];
                r.c   = wide[DATA_W];
                r.v   = (a[DATA_W-1] != b[DATA_W-1]) && (r.res[DATA_W-1] != a[DATA_W-1]);
            end
            OP_LSL:   r.res = a << shamt;
            OP_PASSB: r.res = b;
            OP_PASSA: r.res = a;
            default:  r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the ALU control stage (master) and alu_seq (slave).
// The flags signal exists only when ALU_SEQ_FLAGS_EN is defined.
interface alu_seq_if;
    import alu_pkg::*;

    logic                 start;
    logic [3:0]           operation;
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic [SHAMT_W-1:0]   shamt;
    logic                 busy;
    logic                 done;
    logic [DATA_W-1:0]    result;
    logic                 zero;
    logic                 illegal;
`ifdef ALU_SEQ_FLAGS_EN
    logic [3:0]           flags;

    modport master (output start, operation, a, b, shamt,
                    input  busy, done, result, zero, illegal, flags);
    modport slave  (input  start, operation, a, b, shamt,
                    output busy, done, result, zero, illegal, flags);
`else
    modport master (output start, operation, a, b, shamt,
                    input  busy, done, result, zero, illegal);
    modport slave  (input  start, operation, a, b, shamt,
                    output busy, done, result, zero, illegal);
`endif

endinterface

// File: rtl/alu_shift_iter.sv
// One-bit-per-cycle left shifter with zero fill; last_o marks the final step.
module alu_shift_iter
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [DATA_W-1:0]  data_i,
    output logic [DATA_W-1:0]  data_o,
    output logic               last_o
);

    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  step;
    logic [SHAMT_W-1:0] cnt_q;

    assign step = {data_q[DATA_W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= shamt_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - SHAMT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            data_q <= data_i;
        end else if (cnt_q != '0) begin
            data_q <= step;
        end
    end

    // data_o is the value after this cycle's step so the caller can capture it
    // on the same edge that completes the shift.
    assign data_o = step;
    assign last_o = (cnt_q == SHAMT_W'(1));

endmodule

// File: rtl/alu_seq.sv
// Sequential 64-bit ALU: IDLE/EXEC/SHIFT/DONE FSM with an iterative LSL.
// Define ALU_SEQ_FLAGS_EN to add the {N,Z,C,V} flags output.
module alu_seq
    import alu_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);

    alu_state_e          state_q;
    logic                busy_q;
    logic                done_q;
    logic                zero_q;
    logic                illegal_q;
    logic [DATA_W-1:0]   result_q;

    logic [3:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [SHAMT_W-1:0]  shamt_q;

    logic                accept;
    logic                shift_req;
    logic [DATA_W-1:0]   sh_data;
    logic                sh_last;
    alu_res_t            ev;

    assign accept    = (state_q == S_IDLE) && bus.start;
    assign shift_req = (bus.operation == OP_LSL) && (bus.shamt != '0);

    alu_shift_iter u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept && shift_req),
        .shamt_i (bus.shamt),
        .data_i  (bus.a),
        .data_o  (sh_data),
        .last_o  (sh_last)
    );

    // Operands are captured once at acceptance and never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= bus.operation;
            a_q     <= bus.a;
            b_q     <= bus.b;
            shamt_q <= bus.shamt;
        end
    end

    always_comb begin
        ev = alu_eval(op_q, a_q, b_q, shamt_q);
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic [3:0] flags_q;
    assign bus.flags = flags_q;
`else
    logic unused_cv;
    assign unused_cv = ev.c ^ ev.v;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            flags_q   <= 4'b0000;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q  <= 1'b1;
                        state_q <= shift_req ? S_SHIFT : S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_q  <= ev.res;
                    zero_q    <= (ev.res == '0);
                    illegal_q <= ev.illegal;
`ifdef ALU_SEQ_FLAGS_EN
                    flags_q   <= {ev.res[DATA_W-1], (ev.res == '0), ev.c, ev.v};
`endif
                    done_q    <= 1'b1;
                    state_q   <= S_DONE;
                end
                S_SHIFT: begin
                    if (sh_last) begin
                        result_q  <= sh_data;
                        zero_q    <= (sh_data == '0);
                        illegal_q <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
                        flags_q   <= {sh_data[DATA_W-1], (sh_data == '0), 2'b00};
`endif
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.zero    = zero_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq plus hand-written reset/shift sequences.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    alu_seq_if bus ();

    alu_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [5:0]   sh;
        logic [63:0]  res;
        logic         z;
        logic         ill;
        int           lat;
        logic [3:0]   fl;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one request; lat is the cycle offset (from the accepting edge N)
    // at which done is presented, bcyc the number of cycles busy was high.
    task automatic do_req(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] sh, input bit poke, output int lat, output int bcyc,
                          output logic done_after, output logic busy_after);
        @(negedge clk);
        bus.operation = op;
        bus.a         = a;
        bus.b         = b;
        bus.shamt     = sh;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.operation = 4'b0110;
        bus.a         = ~a;
        bus.b         = ~b;
        bus.shamt     = ~sh;
        lat  = -1;
        bcyc = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus.busy === 1'b1) bcyc++;
            if (poke) bus.start = (k == 3 || k == 30);
            if (bus.done === 1'b1) begin
                lat = k + 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        done_after = bus.done;
        busy_after = bus.busy;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   bcyc;
        logic dn_a;
        logic bs_a;
        bit   seen;

        n_cmp = 0;
        n_bad = 0;
        vt[0]  = '{"and",      4'b0000, 64'hFF00FF00_FF00FF00, 64'h0FF00FF0_0FF00FF0, 6'd0,  64'h0F000F00_0F000F00, 1'b0, 1'b0, 2,  4'b0000};
        vt[1]  = '{"orr",      4'b0001, 64'h0000_00F0,         64'h0000_000F,         6'd0,  64'h0000_00FF,         1'b0, 1'b0, 2,  4'b0000};
        vt[2]  = '{"add_wrap", 4'b0010, 64'hFFFFFFFF_FFFFFFFF, 64'h1,                 6'd0,  64'h0,                 1'b1, 1'b0, 2,  4'b0110};
        vt[3]  = '{"sub_neg",  4'b0110, 64'h5,                 64'h7,                 6'd0,  64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0, 2,  4'b1000};
        vt[4]  = '{"add_ovf",  4'b0010, 64'h7FFFFFFF_FFFFFFFF, 64'h1,                 6'd0,  64'h80000000_00000000, 1'b0, 1'b0, 2,  4'b1001};
        vt[5]  = '{"sub_ovf",  4'b0110, 64'h80000000_00000000, 64'h1,                 6'd0,  64'h7FFFFFFF_FFFFFFFF, 1'b0, 1'b0, 2,  4'b0011};
        vt[6]  = '{"sub_pos",  4'b0110, 64'h7,                 64'h5,                 6'd0,  64'h2,                 1'b0, 1'b0, 2,  4'b0010};
        vt[7]  = '{"lsl_0",    4'b0011, 64'h1234,              64'h0,                 6'd0,  64'h1234,              1'b0, 1'b0, 2,  4'b0000};
        vt[8]  = '{"lsl_1",    4'b0011, 64'h1234,              64'h0,                 6'd1,  64'h2468,              1'b0, 1'b0, 2,  4'b0000};
        vt[9]  = '{"lsl_4",    4'b0011, 64'h80000000_00000001, 64'h0,                 6'd4,  64'h10,                1'b0, 1'b0, 5,  4'b0000};
        vt[10] = '{"ill_0100", 4'b0100, 64'h5,                 64'h3,                 6'd0,  64'h0,                 1'b1, 1'b1, 2,  4'b0100};
        vt[11] = '{"orr_after",4'b0001, 64'hF0,                64'h0F,                6'd0,  64'hFF,                1'b0, 1'b0, 2,  4'b0000};
        vt[12] = '{"pass_b",   4'b0111, 64'h1,                 64'hDEAD,              6'd0,  64'hDEAD,              1'b0, 1'b0, 2,  4'b0000};
        vt[13] = '{"pass_a",   4'b1111, 64'hCAFEF00D_12345678, 64'h9,                 6'd0,  64'hCAFEF00D_12345678, 1'b0, 1'b0, 2,  4'b1000};
        vt[14] = '{"sub_zero", 4'b0110, 64'h3,                 64'h3,                 6'd0,  64'h0,                 1'b1, 1'b0, 2,  4'b0110};
        vt[15] = '{"ill_1010", 4'b1010, 64'hFFFF,              64'hFFFF,              6'd3,  64'h0,                 1'b1, 1'b1, 2,  4'b0100};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.operation = 4'b0000;
        bus.a         = '0;
        bus.b         = '0;
        bus.shamt     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    64'(bus.busy),    64'h0);
        chk("rst_done",    64'(bus.done),    64'h0);
        chk("rst_result",  bus.result,       64'h0);
        chk("rst_zero",    64'(bus.zero),    64'h1);
        chk("rst_illegal", 64'(bus.illegal), 64'h0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("rst_flags",   64'(bus.flags),   64'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_req(vt[i].op, vt[i].a, vt[i].b, vt[i].sh, 1'b0, lat, bcyc, dn_a, bs_a);
            chk({vt[i].name, "_latency"}, 64'(lat),         64'(vt[i].lat));
            chk({vt[i].name, "_busycyc"}, 64'(bcyc),        64'(vt[i].lat));
            chk({vt[i].name, "_donepulse"}, 64'(dn_a),      64'h0);
            chk({vt[i].name, "_idle"},    64'(bs_a),        64'h0);
            chk({vt[i].name, "_result"},  bus.result,       vt[i].res);
            chk({vt[i].name, "_zero"},    64'(bus.zero),    64'(vt[i].z));
            chk({vt[i].name, "_illegal"}, 64'(bus.illegal), 64'(vt[i].ill));
`ifdef ALU_SEQ_FLAGS_EN
            chk({vt[i].name, "_flags"},   64'(bus.flags),   64'(vt[i].fl));
`endif
        end

        // LSL by 63 with start pulses while busy
        do_req(4'b0011, 64'h1, 64'h0, 6'd63, 1'b1, lat, bcyc, dn_a, bs_a);
        chk("lsl63_latency", 64'(lat),      64'd64);
        chk("lsl63_busycyc", 64'(bcyc),     64'd64);
        chk("lsl63_result",  bus.result,    64'h80000000_00000000);
        chk("lsl63_zero",    64'(bus.zero), 64'h0);
        chk("lsl63_noqueue", 64'(bs_a),     64'h0);
        chk("lsl63_donepulse", 64'(dn_a),   64'h0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("lsl63_flags",   64'(bus.flags), 64'b1000);
`endif

        // Reset on the third SHIFT cycle of LSL by 10
        @(negedge clk);
        bus.operation = 4'b0011;
        bus.a         = 64'h1234;
        bus.b         = 64'h0;
        bus.shamt     = 6'd10;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rstshift_busy_before", 64'(bus.busy), 64'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rstshift_busy",    64'(bus.busy),    64'h0);
        chk("rstshift_done",    64'(bus.done),    64'h0);
        chk("rstshift_result",  bus.result,       64'h0);
        chk("rstshift_zero",    64'(bus.zero),    64'h1);
        chk("rstshift_illegal", 64'(bus.illegal), 64'h0);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        chk("rstshift_no_done", 64'(seen), 64'h0);

        // Reset and start in the same cycle: reset wins
        do_req(4'b0001, 64'hF0, 64'h0F, 6'd0, 1'b0, lat, bcyc, dn_a, bs_a);
        chk("pre_rststart_result", bus.result, 64'hFF);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.operation = 4'b0010;
        bus.a         = 64'h1;
        bus.b         = 64'h2;
        bus.shamt     = 6'd0;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        chk("rststart_busy",   64'(bus.busy), 64'h0);
        chk("rststart_result", bus.result,    64'h0);
        chk("rststart_zero",   64'(bus.zero), 64'h1);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        chk("rststart_dropped", 64'(seen), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL provide ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- operation  in  4  ALU operation code from the ALU control stage
- a  in  64  operand A
- b  in  64  operand B
- shamt  in  6  shift amount for LSL
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle completion pulse
- result  out  64  registered result
- zero  out  1  high when result == 0
- illegal  out  1  high with done if operation is unsupported
REQ-002 SHALL register operation, a, b and shamt on acceptance; later changes to these inputs SHALL NOT affect the request in flight.

Function
REQ-003 SHALL decode: 0000 AND; 0001 ORR; 0010 ADD; 0110 SUB (a-b); 0011 LSL (a<<shamt); 0111 pass B; 1111 pass A; every other code is illegal.
REQ-004 SHALL implement FSM states IDLE, EXEC, SHIFT, DONE.
REQ-005 IDLE: start=1 SHALL accept the request; go to SHIFT if op is LSL with shamt!=0, else go to EXEC.
REQ-006 EXEC: compute the result in one cycle; go to DONE.
REQ-007 SHIFT: shift one bit left per cycle, decrementing the count; go to DONE after exactly shamt cycles.
REQ-008 DONE: done=1 for exactly one cycle; go to IDLE.
REQ-009 Latency from start accepted at edge N SHALL be: done at cycle N+2 for non-shift ops and for LSL with shamt=0; done at cycle N+1+shamt for LSL with shamt>=1.
REQ-010 busy SHALL be high in EXEC, SHIFT and DONE, and low in IDLE.
REQ-011 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-012 Arithmetic SHALL wrap modulo 2^64, with no saturation.
REQ-013 LSL SHALL zero-fill; shamt=63 leaves only bit 63 = a[0].
REQ-014 Illegal op SHALL produce result=0 and illegal=1, with the same timing as a non-shift op.
REQ-015 result, zero and illegal SHALL hold their value from DONE until the next request reaches DONE.

Reset
REQ-016 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, result=0, zero=1, illegal=0 (and flags=0 when compiled in).
REQ-017 Reset during EXEC or SHIFT SHALL abort the request with no done pulse.
REQ-018 If reset and start are asserted in the same cycle, reset SHALL win and the request SHALL be dropped.

Configuration
REQ-019 With ALU_SEQ_FLAGS_EN defined, the block SHALL add output flags[3:0] = {N,Z,C,V}, updated in DONE:
- ADD: C = carry out; V = signed overflow
- SUB: C = NOT borrow; V = signed overflow
- all other ops: C = 0, V = 0
- N = result[63]; Z = zero
REQ-020 Without ALU_SEQ_FLAGS_EN, the flags port and its logic SHALL NOT exist; all other behaviour is identical.

Structure
REQ-021 Operation-code constants, the FSM state encoding and the data width (64) SHALL live in shared package alu_pkg, which is also used by the ALU control stage.
REQ-022 The iterative shifter SHALL be a sub-module alu_shift_iter with interface load/shamt/data in and data/last out; the FSM stays in alu_seq.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> done at N+2; result=0, zero=1; flags C=1, V=0 (macro on)
- SUB a=5, b=7 -> result=0xFFFF_FFFF_FFFF_FFFE, zero=0; flags N=1, C=0
- LSL a=1, shamt=63 -> busy for 64 cycles, done at N+64, result=0x8000_0000_0000_0000; start pulses mid-shift ignored
- LSL a=0x1234, shamt=0 -> done at N+2, result=0x1234
- operation=0100 -> done at N+2, illegal=1, result=0; next ORR a=0xF0, b=0x0F -> result=0xFF, illegal=0
- rst_n=0 on 3rd SHIFT cycle of LSL shamt=10 -> no done pulse, IDLE, result=0, zero=1 on the next cycle
